// File: rtl/vending_sequencer_if.sv
// Vending sequencer signal bundle.
// Groups the coin/select/return inputs and the actuator/status outputs of
// vending_sequencer so the controller and its environment share one port.
//   master : the machine front panel / environment (drives i_*, reads o_*)
//   slave  : the sequencer itself (reads i_*, drives o_*)
interface vending_sequencer_if #(
   parameter int unsigned NUM_ITEMS  = 4,
   parameter int unsigned NUM_COINS  = 3,
   parameter int unsigned TOTAL_BITS = 31
);
   logic [NUM_COINS-1:0]  i_input_coin;
   logic [NUM_ITEMS-1:0]  i_select_item;
   logic                  i_trigger_return;
   logic [NUM_ITEMS-1:0]  o_available_item;
   logic [NUM_ITEMS-1:0]  o_output_item;
   logic [NUM_COINS-1:0]  o_return_coin;
   logic                  o_coin_reject;
   logic [TOTAL_BITS-1:0] o_balance;
   logic                  o_busy;

   modport master (
      output i_input_coin, i_select_item, i_trigger_return,
      input  o_available_item, o_output_item, o_return_coin,
             o_coin_reject, o_balance, o_busy
   );

   modport slave (
      input  i_input_coin, i_select_item, i_trigger_return,
      output o_available_item, o_output_item, o_return_coin,
             o_coin_reject, o_balance, o_busy
   );
endinterface

// File: rtl/vending_sequencer.sv
// Vending machine top-level control FSM.
// Sole owner of the balance: accepts coins, dispenses the lowest selected
// affordable item, and returns change greedily (largest coin first) on
// request or after TIMEOUT inactive cycles.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset (balance discarded, no change)
//   bus     : vending_sequencer_if.slave
//             i_input_coin / i_select_item / i_trigger_return in,
//             o_available_item (combinational), o_output_item, o_return_coin,
//             o_coin_reject, o_balance, o_busy (registered)
module vending_sequencer #(
   parameter int unsigned NUM_ITEMS   = 4,
   parameter int unsigned NUM_COINS   = 3,
   parameter int unsigned TOTAL_BITS  = 31,
   parameter int unsigned TIMEOUT     = 100,
   parameter int unsigned MAX_BALANCE = 10000
) (
   input logic                clk,
   input logic                reset_n,
   vending_sequencer_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_RETURN = 2'd2;

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   function automatic logic [TOTAL_BITS-1:0] f_price(input int unsigned idx);
      case (idx)
         0:       return TOTAL_BITS'(400);
         1:       return TOTAL_BITS'(500);
         2:       return TOTAL_BITS'(1000);
         default: return TOTAL_BITS'(2000);
      endcase
   endfunction

   // Coin values must stay ascending in index; the change logic relies on it.
   function automatic logic [TOTAL_BITS-1:0] f_coin_value(input int unsigned idx);
      case (idx)
         0:       return TOTAL_BITS'(100);
         1:       return TOTAL_BITS'(500);
         default: return TOTAL_BITS'(1000);
      endcase
   endfunction

   logic [1:0]            r_state;
   logic [TOTAL_BITS-1:0] r_balance;
   logic [TW-1:0]         r_timer;
   logic [NUM_ITEMS-1:0]  r_output_item;
   logic [NUM_COINS-1:0]  r_return_coin;
   logic                  r_coin_reject;

   logic [TOTAL_BITS-1:0] w_coin_sum;
   logic                  w_coin_any;
   logic                  w_coin_accept;
   logic                  w_coin_refuse;
   logic [TOTAL_BITS-1:0] w_coin_add;
   logic [NUM_ITEMS-1:0]  w_sel_onehot;
   logic [TOTAL_BITS-1:0] w_sel_price;
   logic                  w_dispense;
   logic [TOTAL_BITS-1:0] w_debit;
   logic                  w_activity;
   logic [NUM_COINS-1:0]  w_eject;
   logic [TOTAL_BITS-1:0] w_eject_val;

   always_comb begin
      w_coin_sum = '0;
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
         if (bus.i_input_coin[i]) w_coin_sum = w_coin_sum + f_coin_value(i);
      end
      w_coin_any    = |bus.i_input_coin;
      // The whole cycle's coins are taken or refused together; never in RETURN.
      w_coin_accept = w_coin_any && (r_state != S_RETURN) &&
                      ((r_balance + w_coin_sum) <= TOTAL_BITS'(MAX_BALANCE));
      w_coin_refuse = w_coin_any && !w_coin_accept;
      w_coin_add    = w_coin_accept ? w_coin_sum : '0;
   end

   // Descending scan so the lowest set select bit is the one left standing.
   always_comb begin
      w_sel_onehot = '0;
      w_sel_price  = '0;
      for (int unsigned i = NUM_ITEMS; i > 0; i--) begin
         if (bus.i_select_item[i-1]) begin
            w_sel_onehot      = '0;
            w_sel_onehot[i-1] = 1'b1;
            w_sel_price       = f_price(i-1);
         end
      end
      // Affordability uses the balance before this cycle's coins.
      w_dispense = (r_state == S_ACTIVE) && (|bus.i_select_item) &&
                   (w_sel_price <= r_balance);
      w_debit    = w_dispense ? w_sel_price : '0;
      w_activity = w_coin_accept || w_dispense;
   end

   // Ascending scan keeps the largest coin that still fits the balance.
   always_comb begin
      w_eject     = '0;
      w_eject_val = '0;
      for (int unsigned i = 0; i < NUM_COINS; i++) begin
         if (f_coin_value(i) <= r_balance) begin
            w_eject     = '0;
            w_eject[i]  = 1'b1;
            w_eject_val = f_coin_value(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_balance     <= '0;
         r_timer       <= '0;
         r_output_item <= '0;
         r_return_coin <= '0;
         r_coin_reject <= 1'b0;
      end else begin
         r_output_item <= '0;
         r_return_coin <= '0;
         r_coin_reject <= w_coin_refuse;
         case (r_state)
            S_IDLE: begin
               if (w_coin_accept) begin
                  r_balance <= r_balance + w_coin_sum;
                  r_timer   <= TW'(TIMEOUT);
                  r_state   <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               r_balance <= r_balance + w_coin_add - w_debit;
               if (w_dispense) r_output_item <= w_sel_onehot;
               if (w_activity) r_timer <= TW'(TIMEOUT);
               else            r_timer <= r_timer - 1'b1;
               // Timer holds the inactive cycles still allowed; the last one
               // moves to RETURN.
               if (bus.i_trigger_return || (!w_activity && r_timer == TW'(1)))
                  r_state <= S_RETURN;
            end
            S_RETURN: begin
               // Leaving only once the balance reads 0 keeps o_busy high
               // through the final eject pulse.
               if (r_balance == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_balance     <= r_balance - w_eject_val;
                  r_return_coin <= w_eject;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.o_available_item = '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         if ((r_state == S_ACTIVE) && (f_price(i) <= r_balance))
            bus.o_available_item[i] = 1'b1;
      end
   end

   assign bus.o_output_item = r_output_item;
   assign bus.o_return_coin = r_return_coin;
   assign bus.o_coin_reject = r_coin_reject;
   assign bus.o_balance     = r_balance;
   assign bus.o_busy        = (r_state == S_RETURN);

endmodule

// File: tb/tb_vending_sequencer.sv
// Self-checking bench for vending_sequencer: directed scenarios followed by
// random coin/select/return traffic, all compared against a transaction-level
// model of the machine (integer balance, inactivity count, change queue).
module tb_vending_sequencer;

   localparam int unsigned NI   = 4;
   localparam int unsigned NC   = 3;
   localparam int unsigned TBW  = 31;
   localparam int unsigned TO   = 100;
   localparam int unsigned MAXB = 10000;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   vending_sequencer_if #(.NUM_ITEMS(NI), .NUM_COINS(NC), .TOTAL_BITS(TBW)) bus ();

   vending_sequencer #(
      .NUM_ITEMS  (NI),
      .NUM_COINS  (NC),
      .TOTAL_BITS (TBW),
      .TIMEOUT    (TO),
      .MAX_BALANCE(MAXB)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int price [NI] = '{400, 500, 1000, 2000};
   int cval  [NC] = '{100, 500, 1000};

   int       m_bal;
   bit       m_active;     // customer session open
   bit       m_returning;  // paying out change
   int       m_idle;       // consecutive inactive cycles in the session
   int       m_q[$];       // change still to be paid, in payout order
   logic [NI-1:0] e_item;
   logic [NC-1:0] e_ret;
   bit       e_rej;

   task automatic model_reset();
      m_bal = 0; m_active = 0; m_returning = 0; m_idle = 0;
      m_q.delete();
      e_item = '0; e_ret = '0; e_rej = 0;
   endtask

   task automatic plan_change(input int amount);
      int b;
      b = amount;
      m_q.delete();
      for (int k = NC - 1; k >= 0; k--) begin
         while (b >= cval[k]) begin
            m_q.push_back(k);
            b -= cval[k];
         end
      end
   endtask

   task automatic model_step(input logic [NC-1:0] coin, input logic [NI-1:0] sel, input bit ret);
      int csum, sidx, k;
      bit accept, disp;
      csum = 0;
      for (int i = 0; i < NC; i++) if (coin[i]) csum += cval[i];
      sidx = -1;
      for (int i = NI - 1; i >= 0; i--) if (sel[i]) sidx = i;
      e_item = '0; e_ret = '0; e_rej = 0;
      if (m_returning) begin
         e_rej = (coin != 0);
         if (m_q.size() > 0) begin
            k = m_q.pop_front();
            m_bal -= cval[k];
            e_ret[k] = 1'b1;
         end else begin
            m_returning = 0;
         end
      end else begin
         accept = (coin != 0) && (m_bal + csum <= MAXB);
         e_rej  = (coin != 0) && !accept;
         if (!m_active) begin
            if (accept) begin
               m_bal += csum;
               m_active = 1;
               m_idle = 0;
            end
         end else begin
            disp = (sidx >= 0) && (price[sidx] <= m_bal);
            if (disp) e_item[sidx] = 1'b1;
            m_bal = m_bal + (accept ? csum : 0) - (disp ? price[sidx] : 0);
            if (accept || disp) m_idle = 0;
            else m_idle++;
            if (ret || m_idle == TO) begin
               m_active = 0;
               m_returning = 1;
               plan_change(m_bal);
            end
         end
      end
   endtask

   task automatic check_all();
      logic [NI-1:0] avail;
      avail = '0;
      for (int i = 0; i < NI; i++) if (m_active && price[i] <= m_bal) avail[i] = 1'b1;
      chk("balance",   64'(bus.o_balance),        64'(m_bal));
      chk("out_item",  64'(bus.o_output_item),    64'(e_item));
      chk("ret_coin",  64'(bus.o_return_coin),    64'(e_ret));
      chk("reject",    64'(bus.o_coin_reject),    64'(e_rej));
      chk("busy",      64'(bus.o_busy),           64'(m_returning));
      chk("available", 64'(bus.o_available_item), 64'(avail));
   endtask

   // Drive one cycle of inputs, advance the model on the same edge, compare.
   task automatic cycle(input logic [NC-1:0] coin, input logic [NI-1:0] sel, input bit ret);
      bus.i_input_coin     = coin;
      bus.i_select_item    = sel;
      bus.i_trigger_return = ret;
      @(posedge clk);
      model_step(coin, sel, ret);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [NC-1:0] c;
      logic [NI-1:0] s;
      bus.i_input_coin     = '0;
      bus.i_select_item    = '0;
      bus.i_trigger_return = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1000 in, buy item 0
      cycle(3'b100, '0, 0);
      cycle('0, 4'b0001, 0);
      chk("buy0_item", 64'(bus.o_output_item), 64'd1);
      chk("buy0_bal", 64'(bus.o_balance), 64'd600);
      chk("buy0_avail", 64'(bus.o_available_item), 64'b0011);
      cycle('0, '0, 1);
      idle(5);

      // Balance 500, unaffordable select
      cycle(3'b010, '0, 0);
      cycle('0, 4'b0100, 0);
      chk("poor_item", 64'(bus.o_output_item), 64'd0);
      chk("poor_bal", 64'(bus.o_balance), 64'd500);
      // Select was not activity: the session still expires TO cycles after the coin
      idle(TO - 2);
      chk("poor_busy_pre", 64'(bus.o_busy), 64'd0);
      idle(1);
      chk("poor_busy_at", 64'(bus.o_busy), 64'd1);
      idle(3);

      // 1600 -> 1000, 500, 100 change
      cycle(3'b101, '0, 0);
      cycle(3'b010, '0, 0);
      cycle('0, '0, 1);
      cycle('0, '0, 0);
      chk("chg_1000", 64'(bus.o_return_coin), 64'b100);
      cycle('0, '0, 0);
      chk("chg_500", 64'(bus.o_return_coin), 64'b010);
      cycle('0, '0, 0);
      chk("chg_100", 64'(bus.o_return_coin), 64'b001);
      chk("chg_busy", 64'(bus.o_busy), 64'd1);
      idle(2);

      // Timeout restarted by a coin on cycle TO-1
      cycle(3'b010, '0, 0);
      idle(TO - 2);
      cycle(3'b001, '0, 0);
      idle(TO - 1);
      chk("to_restart", 64'(bus.o_busy), 64'd0);
      idle(1);
      chk("to_expire", 64'(bus.o_busy), 64'd1);
      idle(5);

      // Ceiling: reach 9600, overflow coin refused, then coin+select together
      for (int i = 0; i < 9; i++) cycle(3'b100, '0, 0);
      cycle(3'b011, '0, 0);
      cycle(3'b100, '0, 0);
      chk("cap_rej", 64'(bus.o_coin_reject), 64'd1);
      chk("cap_bal", 64'(bus.o_balance), 64'd9600);
      cycle(3'b001, 4'b0010, 0);
      chk("cap_mix_bal", 64'(bus.o_balance), 64'd9200);
      chk("cap_mix_item", 64'(bus.o_output_item), 64'b0010);
      // Select and return together: dispense first, then pay out the rest
      cycle('0, 4'b1000, 1);
      idle(12);

      // Reset mid-RETURN at 700
      cycle(3'b011, '0, 0);
      cycle(3'b001, '0, 0);
      cycle('0, '0, 1);
      chk("rst_pre_bal", 64'(bus.o_balance), 64'd700);
      do_reset();
      chk("rst_bal", 64'(bus.o_balance), 64'd0);
      idle(8);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 300) == 0) begin
            idle(TO + 5);
         end else begin
            c = ($urandom_range(0, 3) == 0) ? NC'($urandom_range(1, 7)) : '0;
            s = ($urandom_range(0, 5) == 0) ? NI'($urandom_range(1, 15)) : '0;
            cycle(c, s, ($urandom_range(0, 59) == 0));
         end
         if ($urandom_range(0, 1500) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
